mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported data memory model (valid/addr/write_enabled/w_data in, r_data/status out; status 00 = ready, 01 = busy, 10 = done).
- Shares the memory between instruction fetch (IF, read-only) and the data-memory stage (DM, read/write).
- Latches the winning request, holds the memory-side request stable for the whole transaction, and returns a one-cycle done pulse with registered read data to the winner.

Parameters:
- DM_FIXED_PRIORITY, 1, fixed-priority mode winner when both ports request: 1 = DM wins, 0 = IF wins.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  IF read request (level, held until if_done)
- if_addr  in  32  IF read address
- if_done  out  1  one-cycle completion pulse to IF
- if_rdata  out  32  IF read data, registered
- dm_req  in  1  DM request (level, held until dm_done)
- dm_addr  in  32  DM address
- dm_we  in  1  DM write enable
- dm_wdata  in  32  DM write data
- dm_done  out  1  one-cycle completion pulse to DM
- dm_rdata  out  32  DM read data, registered
- mem_valid  out  1  request strobe to memory
- mem_addr  out  32  memory address
- mem_write_enabled  out  1  memory write enable
- mem_w_data  out  32  memory write data
- mem_r_data  in  32  memory read data
- mem_status  in  2  memory status (00/01/10)
- grant_dm  out  1  1 = current or last transaction owned by DM; debug/trace

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- States: IDLE, ISSUE, WAIT, RESP; 2-bit state register.
- Reset values:
  - State = IDLE.
  - All outputs 0: mem_valid, mem_addr, mem_write_enabled, mem_w_data, if_done, dm_done, if_rdata, dm_rdata, grant_dm.
  - Round-robin pointer (if compiled in) = 0.
- IDLE:
  - No request: stay IDLE.
  - Any req high: select the winner.
  - Latch winner id, addr, we, wdata. For IF, we = 0 and wdata = 0.
  - Update grant_dm, go ISSUE.
- ISSUE:
  - mem_valid = 1.
  - If mem_status == 00, go WAIT next edge.
  - Otherwise, e.g. a stale 10 after reset, stay ISSUE with mem_valid held.
- WAIT:
  - mem_valid = 0.
  - On mem_status == 10: capture mem_r_data into the winner's rdata register (reads only; writes leave rdata unchanged), go RESP.
  - Status 00 or 01: stay.
- RESP:
  - Winner's done = 1 for exactly this cycle; go IDLE.
- Memory-side drive:
  - mem_addr, mem_write_enabled, mem_w_data driven from the latched registers in ISSUE, WAIT and RESP, so they are stable through memory completion.
  - All three are 0 in IDLE.
- Requester rules:
  - req must stay high with stable payload until done.
  - Payload is latched at grant; later changes are ignored.
  - Requester drops req on the edge ending the done cycle.
  - A req still high in the following IDLE cycle is a new request.
- Latency, with memory latency L:
  - req high in IDLE cycle 0 -> mem_valid cycle 1 -> mem_status 10 cycle L+2 -> done cycle L+3.
  - Earliest next grant is cycle L+4; mem_valid again in cycle L+5.
- Both req high in IDLE: winner chosen per priority (see Optional Feature). The loser waits and is granted at the next IDLE if still requesting.
- Stray input: mem_status == 10 while in IDLE or ISSUE is ignored, apart from ISSUE holding.
- rdata hold: if_rdata and dm_rdata keep their value until that port's next read completion.
- Reset mid-transaction: state returns to IDLE and the transaction is dropped with no done pulse. The memory shares the reset, so no cleanup handshake is needed.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - 1-bit last-grant pointer, updated at every grant.
  - On simultaneous requests the port not granted last wins; DM_FIXED_PRIORITY is ignored.
  - Guarantees each port waits at most one transaction.
- Undefined:
  - Fixed priority per DM_FIXED_PRIORITY; the losing port may starve.
  - No pointer register is built.

Test Plan:
- Single IF read: L = 2, memory word 0x100 = 0xDEADBEEF, if_req at cycle 0, if_addr = 0x100 -> mem_valid cycle 1 only, if_done cycle 5 only, if_rdata = 0xDEADBEEF, dm_done never, grant_dm = 0.
- DM write then read: dm write 0x200 <- 0x12345678, then dm read 0x200 -> mem_write_enabled = 1 with mem_w_data = 0x12345678 held through WAIT; second dm_done gives dm_rdata = 0x12345678; if_rdata unchanged.
- Simultaneous fixed priority, feature off, DM_FIXED_PRIORITY = 1: both req at cycle 0 -> DM served first (dm_done cycle L+3), IF next (if_done cycle 2L+7).
- Round robin, feature on, both req held continuously for 4 transactions -> grant order DM, IF, DM, IF, with pointer starting at 0 after reset.
- Payload change: if_addr switched from 0x100 to 0x300 after grant -> mem_addr stays 0x100, if_rdata = word at 0x100.
- Reset mid-op: reset asserted in WAIT -> next cycle state IDLE, all outputs 0, no done pulse; a fresh request afterwards completes normally with standard latency.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle between the mem_arbiter, its two requesters (IF, DM) and the
// single-ported data memory; slave = arbiter side, master = environment.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_write_enabled;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  logic [1:0]  mem_status;
  logic        grant_dm;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_addr, dm_we, dm_wdata,
    input  mem_r_data, mem_status,
    output if_done, if_rdata,
    output dm_done, dm_rdata,
    output mem_valid, mem_addr,
    output mem_write_enabled, mem_w_data,
    output grant_dm
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_addr, dm_we, dm_wdata,
    output mem_r_data, mem_status,
    input  if_done, if_rdata,
    input  dm_done, dm_rdata,
    input  mem_valid, mem_addr,
    input  mem_write_enabled, mem_w_data,
    input  grant_dm
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (IF/DM) arbiter and sequencer for the single-ported data memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module mem_arbiter #(
  parameter bit DM_FIXED_PRIORITY = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_DONE  = 2'b10;

  state_t      state_q, state_d;
  logic        win_dm_q, win_dm_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        pick_dm;
  logic        any_req;
  logic        busy;

  assign any_req = bus.if_req | bus.dm_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_dm_q, last_dm_d;

  // On contention the port that did not win last time goes first
  always_comb begin
    pick_dm = bus.dm_req;
    if (bus.dm_req && bus.if_req) pick_dm = ~last_dm_q;
  end

  always_comb begin
    last_dm_d = last_dm_q;
    if (state_q == IDLE && any_req) last_dm_d = pick_dm;
  end

  always_ff @(posedge clk) begin
    if (reset) last_dm_q <= 1'b0;
    else       last_dm_q <= last_dm_d;
  end
`else
  always_comb begin
    pick_dm = bus.dm_req;
    if (bus.dm_req && bus.if_req) pick_dm = DM_FIXED_PRIORITY;
  end
`endif

  always_comb begin
    state_d    = state_q;
    win_dm_d   = win_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          win_dm_d = pick_dm;
          addr_d   = pick_dm ? bus.dm_addr : bus.if_addr;
          we_d     = pick_dm & bus.dm_we;
          wdata_d  = pick_dm ? bus.dm_wdata : '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // A leftover done status keeps the strobe up until memory is ready
        if (bus.mem_status == ST_READY) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_status == ST_DONE) begin
          if (!we_q) begin
            if (win_dm_q) dm_rdata_d = bus.mem_r_data;
            else          if_rdata_d = bus.mem_r_data;
          end
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      win_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      win_dm_q   <= win_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign busy = (state_q != IDLE);

  assign bus.mem_valid         = (state_q == ISSUE);
  assign bus.mem_addr          = busy ? addr_q : '0;
  assign bus.mem_write_enabled = busy & we_q;
  assign bus.mem_w_data        = busy ? wdata_q : '0;
  assign bus.if_done           = (state_q == RESP) & ~win_dm_q;
  assign bus.dm_done           = (state_q == RESP) & win_dm_q;
  assign bus.if_rdata          = if_rdata_q;
  assign bus.dm_rdata          = dm_rdata_q;
  assign bus.grant_dm          = win_dm_q;

endmodule
